// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-bit CPU datapath.
// Owns PC and IR, registers every decoded control, and resolves j/beq in WB.
module cpu_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        INSTR_VALID,
  input  logic        ZERO,
  input  logic        BUSYWAIT,
  output logic [31:0] PC,
  output logic [2:0]  WRITEREG,
  output logic [2:0]  READREG1,
  output logic [2:0]  READREG2,
  output logic [7:0]  IMMEDIATE,
  output logic [2:0]  ALUOP,
  output logic        COMPLEMENT_FLAG,
  output logic        IMMEDIATE_FLAG,
  output logic        WRITEENABLE,
  output logic        WB_SEL,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic        ILLEGAL
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t state, next_state;

  logic [31:0] ir_q;
  logic        zero_q;
  logic        wr_q, mr_q, mw_q, jmp_q, beq_q;

  logic [2:0]  dec_aluop;
  logic        dec_comp, dec_imm, dec_we, dec_wbsel;
  logic        dec_mr, dec_mw, dec_jmp, dec_beq, dec_illegal;

  logic        we_nxt, mr_nxt, mw_nxt, ill_nxt;
  logic        taken;
  logic [31:0] off_ext;
  logic [31:0] pc_next;

  // IR[23:19] carry no field for this instruction set.
  logic unused_ir;
  assign unused_ir = ^ir_q[23:19];

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= S_FETCH;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (INSTR_VALID) next_state = S_DECODE;
      S_DECODE: next_state = S_EXEC;
      S_EXEC:   next_state = (mr_q || mw_q) ? S_MEM : S_WB;
      S_MEM:    if (!BUSYWAIT) next_state = S_WB;
      S_WB:     next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end

  // Opcode decode of the latched IR
  always_comb begin
    dec_aluop   = 3'b000;
    dec_comp    = 1'b0;
    dec_imm     = 1'b0;
    dec_we      = 1'b0;
    dec_wbsel   = 1'b0;
    dec_mr      = 1'b0;
    dec_mw      = 1'b0;
    dec_jmp     = 1'b0;
    dec_beq     = 1'b0;
    dec_illegal = 1'b0;
    case (ir_q[7:0])
      8'd0:  begin dec_imm = 1'b1; dec_we = 1'b1; end
      8'd1:  dec_we = 1'b1;
      8'd2:  begin dec_aluop = 3'b001; dec_we = 1'b1; end
      8'd3:  begin dec_aluop = 3'b001; dec_comp = 1'b1; dec_we = 1'b1; end
      8'd4:  begin dec_aluop = 3'b010; dec_we = 1'b1; end
      8'd5:  begin dec_aluop = 3'b011; dec_we = 1'b1; end
      8'd6:  dec_jmp = 1'b1;
      8'd7:  begin dec_aluop = 3'b001; dec_comp = 1'b1; dec_beq = 1'b1; end
      8'd8:  begin dec_imm = 1'b1; dec_mr = 1'b1; dec_wbsel = 1'b1; dec_we = 1'b1; end
      8'd9:  begin dec_mr = 1'b1; dec_wbsel = 1'b1; dec_we = 1'b1; end
      8'd10: begin dec_imm = 1'b1; dec_mw = 1'b1; end
      8'd11: dec_mw = 1'b1;
      default: dec_illegal = 1'b1;
    endcase
  end

  // Strobe outputs: next values derived from the transition being taken
  always_comb begin
    we_nxt  = wr_q && (state == S_EXEC || state == S_MEM) && (next_state == S_WB);
    mr_nxt  = mr_q && (next_state == S_MEM);
    mw_nxt  = mw_q && (next_state == S_MEM);
    ill_nxt = (state == S_DECODE) && dec_illegal;
  end

  assign off_ext = {{24{ir_q[31]}}, ir_q[31:24]};
  assign taken   = jmp_q || (beq_q && zero_q);
  assign pc_next = PC + 32'd1 + (taken ? off_ext : '0);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      PC              <= RESET_PC;
      ir_q            <= '0;
      zero_q          <= 1'b0;
      WRITEREG        <= '0;
      READREG1        <= '0;
      READREG2        <= '0;
      IMMEDIATE       <= '0;
      ALUOP           <= '0;
      COMPLEMENT_FLAG <= 1'b0;
      IMMEDIATE_FLAG  <= 1'b0;
      WB_SEL          <= 1'b0;
      wr_q            <= 1'b0;
      mr_q            <= 1'b0;
      mw_q            <= 1'b0;
      jmp_q           <= 1'b0;
      beq_q           <= 1'b0;
      WRITEENABLE     <= 1'b0;
      MEM_READ        <= 1'b0;
      MEM_WRITE       <= 1'b0;
      ILLEGAL         <= 1'b0;
    end else begin
      WRITEENABLE <= we_nxt;
      MEM_READ    <= mr_nxt;
      MEM_WRITE   <= mw_nxt;
      ILLEGAL     <= ill_nxt;
      case (state)
        S_FETCH: if (INSTR_VALID) ir_q <= INSTRUCTION;
        S_DECODE: begin
          WRITEREG        <= ir_q[26:24];
          READREG1        <= ir_q[18:16];
          READREG2        <= ir_q[10:8];
          IMMEDIATE       <= ir_q[15:8];
          ALUOP           <= dec_aluop;
          COMPLEMENT_FLAG <= dec_comp;
          IMMEDIATE_FLAG  <= dec_imm;
          WB_SEL          <= dec_wbsel;
          wr_q            <= dec_we;
          mr_q            <= dec_mr;
          mw_q            <= dec_mw;
          jmp_q           <= dec_jmp;
          beq_q           <= dec_beq;
        end
        S_EXEC:  zero_q <= ZERO;
        S_WB:    PC <= pc_next;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle instruction sequencer for the 8-bit CPU datapath: owns the PC and instruction register, fetches from instruction memory with a valid handshake, and decodes each instruction. It drives the register-file, ALU-mux and data-memory controls through FETCH/DECODE/EXEC/MEM/WB states, and resolves `j`/`beq`. It replaces the free-running PC adder and the purely combinational control decode that sit beside the register file and ALU.

## Interface
Parameters:
- `RESET_PC`, 32'd0: PC value loaded on reset.

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `INSTRUCTION`  in  32  instruction memory read data.
- `INSTR_VALID`  in  1  high when `INSTRUCTION` corresponds to the current `PC`.
- `ZERO`  in  1  ALU result-is-zero flag.
- `BUSYWAIT`  in  1  data memory busy; high while an access is in progress.
- `PC`  out  32  current instruction address.
- `WRITEREG`, `READREG1`, `READREG2`  out  3 each  register-file addresses, decoded from the IR.
- `IMMEDIATE`  out  8  IR[15:8].
- `ALUOP`  out  3  000 forward, 001 add, 010 and, 011 or.
- `COMPLEMENT_FLAG`  out  1  selects the negated `REGOUT2`.
- `IMMEDIATE_FLAG`  out  1  selects `IMMEDIATE` as ALU operand 2.
- `WRITEENABLE`  out  1  register-file write strobe, one cycle.
- `WB_SEL`  out  1  0 = ALU result, 1 = memory read data.
- `MEM_READ`, `MEM_WRITE`  out  1 each  data memory requests.
- `ILLEGAL`  out  1  one-cycle pulse when an undefined opcode is decoded.

## Operation
- IR fields:
  - opcode IR[7:0]
  - READREG2 IR[10:8]
  - IMMEDIATE IR[15:8]
  - READREG1 IR[18:16]
  - WRITEREG IR[26:24]
  - OFFSET IR[31:24], signed word offset
- States and transitions:
  - FETCH: wait for `INSTR_VALID`=1, then latch `INSTRUCTION` into the IR and go to DECODE.
  - DECODE: register all control outputs from the opcode, then go to EXEC.
  - EXEC: ALU settles; `ZERO` is sampled at the end of this cycle. Memory opcodes go to MEM; all others go to WB.
  - MEM: `MEM_READ` or `MEM_WRITE` is held from MEM entry until the first edge that samples `BUSYWAIT`=0, then go to WB.
  - WB: `WRITEENABLE` pulses if the opcode writes a register; PC updates; go to FETCH.
- Opcode decode:
  - 0 loadi: fwd, imm=1, we.
  - 1 mov: fwd, we.
  - 2 add: add, we.
  - 3 sub: add, comp=1, we.
  - 4 and: and, we.
  - 5 or: or, we.
  - 6 j: no ALU use.
  - 7 beq: add, comp=1, no we.
  - 8 lwd: fwd, imm=1, MEM_READ, WB_SEL=1, we.
  - 9 lwi: fwd, imm=0, MEM_READ, WB_SEL=1, we.
  - 10 swd: fwd, imm=1, MEM_WRITE; write data is `REGOUT1`.
  - 11 swi: fwd, imm=0, MEM_WRITE; write data is `REGOUT1`.
  - Any other opcode: all controls 0, `ILLEGAL` pulses in DECODE, and the instruction executes as a NOP.
- PC update in WB, in 32-bit wrap-around arithmetic:
  - default: PC+1.
  - `j`: PC+1+sext(OFFSET).
  - `beq` with the sampled `ZERO`=1: PC+1+sext(OFFSET); otherwise PC+1.
- `WRITEENABLE`, `MEM_READ` and `MEM_WRITE` are never asserted in FETCH or DECODE. `MEM_READ` and `MEM_WRITE` are never high together.

## Timing
- Reset values:
  - `PC`=`RESET_PC`; IR=0; state FETCH.
  - Every control output is 0, including `WB_SEL` and `ILLEGAL`.
  - Reset takes effect asynchronously; memory requests drop immediately even mid-MEM.
- Latency, with `INSTR_VALID` already high:
  - ALU, j and beq instructions: 4 cycles from FETCH entry to the next FETCH.
  - Memory instructions: 5+N cycles, where N is the number of edges that sample `BUSYWAIT`=1.
- Output timing: all outputs are registered. The decoded controls are stable from the DECODE edge through the end of WB; they change only on the next DECODE or on reset.
- Stall in FETCH: `PC` is held constant while `INSTR_VALID`=0.
- Wrap-around:
  - PC=32'hFFFF_FFFF with no branch wraps to 0.
  - A negative offset below 0 wraps modulo 2^32.
- `BUSYWAIT` already low on MEM entry: exactly one MEM cycle.

## Test plan
- Reset released with `RESET_PC`=0 and the `INSTR_VALID` input tied high → `PC` goes 0,1,2 at the WB edges, 4 cycles apart. All controls are 0 during FETCH.
- add (opcode 2) with READREG1=1, READREG2=2, WRITEREG=3 → in DECODE, `ALUOP`=001 and COMP=0. `WRITEENABLE` is high for exactly one cycle in WB with `WRITEREG`=3.
- beq at PC=5 with OFFSET=8'hFE:
  - `ZERO`=1 in EXEC → next PC=4.
  - `ZERO`=0 → next PC=6.
  - `WRITEENABLE` stays 0 in both cases.
- lwd with `BUSYWAIT` high for 3 cycles → `MEM_READ` is high for 4 cycles, then `WRITEENABLE` and `WB_SEL`=1 for one cycle. Total of 8 cycles.
- `RESET` asserted low during MEM of swd → `MEM_WRITE` drops without waiting for a clock edge. After release, `PC`=`RESET_PC` and the state is FETCH.
- Opcode 8'hFF → `ILLEGAL` is a one-cycle pulse, no write or memory request occurs, and next PC = PC+1. `INSTR_VALID`=0 for 5 cycles holds `PC`.
